// File: rtl/cook_timer.sv
`default_nettype none
// ============================================================================
// Module   : cook_timer
// Purpose  : Microwave cook-time controller with a 1 Hz countdown and
//            heater/lamp sequencing. COOK_TIMER_DONE_BEEP_EN adds a
//            3-second completion beep.
// Revision : 1.0  initial release
// ============================================================================
module cook_timer #(
   parameter int TICK_DIV = 50000000,
   parameter int ADD_STEP = 30,
   parameter int MAX_SEC  = 511
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       add_sec_i,
   input  logic       start_i,
   input  logic       stop_i,
   input  logic       door_open_i,
   output logic [8:0] seconds_o,
   output logic [1:0] state_o,
   output logic       magnetron_o,
   output logic       lamp_o,
   output logic       done_o,
   output logic       beep_o
);

   localparam int              c_pw     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [c_pw-1:0] c_last   = c_pw'(TICK_DIV - 1);
   localparam logic [9:0]      c_step10 = 10'(ADD_STEP);
   localparam logic [9:0]      c_max10  = 10'(MAX_SEC);
   // Quick-start / post-DONE load value, kept within the ceiling
   localparam logic [8:0]      c_load   = (ADD_STEP > MAX_SEC) ? 9'(MAX_SEC) : 9'(ADD_STEP);

   localparam logic [1:0] c_idle  = 2'b00;
   localparam logic [1:0] c_run   = 2'b01;
   localparam logic [1:0] c_pause = 2'b10;
   localparam logic [1:0] c_done  = 2'b11;

   logic [1:0]      r_state;
   logic [8:0]      r_sec;
   logic [c_pw-1:0] r_presc;
   logic            r_mag;
   logic            r_lamp;
   logic            r_done;

   logic [1:0]      w_state_nxt;
   logic [8:0]      w_sec_nxt;
   logic [c_pw-1:0] w_presc_nxt;
   logic [9:0]      w_sum;
   logic [8:0]      w_sat;
   logic            w_presc_en;
   logic            w_tick;

`ifdef COOK_TIMER_DONE_BEEP_EN
   assign w_presc_en = (r_state == c_run) || (r_state == c_done);
`else
   assign w_presc_en = (r_state == c_run);
`endif

   assign w_tick = w_presc_en && (r_presc == c_last);
   assign w_sum  = {1'b0, r_sec} + c_step10;
   assign w_sat  = (w_sum > c_max10) ? c_max10[8:0] : w_sum[8:0];

   always_comb begin
      w_state_nxt = r_state;
      w_sec_nxt   = r_sec;
      case (r_state)
         c_idle: begin
            if (stop_i) begin
               w_sec_nxt = 9'd0;
            end else if (start_i && !door_open_i) begin
               if (r_sec == 9'd0) w_sec_nxt = c_load;
               w_state_nxt = c_run;
            end else if (add_sec_i) begin
               w_sec_nxt = w_sat;
            end
         end
         c_run: begin
            if (stop_i || door_open_i) begin
               w_state_nxt = c_pause;
            end else if (add_sec_i) begin
               w_sec_nxt = w_tick ? (w_sat - 9'd1) : w_sat;
            end else if (w_tick) begin
               if (r_sec <= 9'd1) begin
                  w_sec_nxt   = 9'd0;
                  w_state_nxt = c_done;
               end else begin
                  w_sec_nxt = r_sec - 9'd1;
               end
            end
         end
         c_pause: begin
            if (stop_i) begin
               w_sec_nxt   = 9'd0;
               w_state_nxt = c_idle;
            end else if (start_i && !door_open_i && (r_sec != 9'd0)) begin
               w_state_nxt = c_run;
            end else if (add_sec_i && !start_i) begin
               w_sec_nxt = w_sat;
            end
         end
         default: begin
            if (stop_i || door_open_i || start_i) begin
               w_sec_nxt   = 9'd0;
               w_state_nxt = c_idle;
            end else if (add_sec_i) begin
               w_sec_nxt   = c_load;
               w_state_nxt = c_idle;
            end
         end
      endcase
   end

   // Leaving or changing state discards any partial second
   always_comb begin
      w_presc_nxt = '0;
      if (w_presc_en && (w_state_nxt == r_state))
         w_presc_nxt = w_tick ? '0 : (r_presc + c_pw'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_idle;
         r_sec   <= 9'd0;
         r_presc <= '0;
         r_mag   <= 1'b0;
         r_lamp  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sec   <= w_sec_nxt;
         r_presc <= w_presc_nxt;
         r_mag   <= (w_state_nxt == c_run);
         r_lamp  <= (w_state_nxt == c_run) || door_open_i;
         r_done  <= (w_state_nxt == c_done);
      end
   end

`ifdef COOK_TIMER_DONE_BEEP_EN
   logic [1:0] r_bcnt;
   logic       r_beep;
   logic [1:0] w_bcnt_nxt;

   // Count completion ticks, saturating at 3; beep while fewer than 3 seen
   always_comb begin
      w_bcnt_nxt = r_bcnt;
      if (w_state_nxt != c_done)
         w_bcnt_nxt = 2'd0;
      else if ((r_state == c_done) && w_tick && (r_bcnt != 2'd3))
         w_bcnt_nxt = r_bcnt + 2'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bcnt <= 2'd0;
         r_beep <= 1'b0;
      end else begin
         r_bcnt <= w_bcnt_nxt;
         r_beep <= (w_state_nxt == c_done) && (w_bcnt_nxt != 2'd3);
      end
   end

   assign beep_o = r_beep;
`else
   assign beep_o = 1'b0;
`endif

   assign seconds_o   = r_sec;
   assign state_o     = r_state;
   assign magnetron_o = r_mag;
   assign lamp_o      = r_lamp;
   assign done_o      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cook_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cook_timer
// Purpose  : Directed self-checking bench for cook_timer (TICK_DIV = 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_cook_timer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       add_sec_i = 1'b0;
   logic       start_i = 1'b0;
   logic       stop_i = 1'b0;
   logic       door_open_i = 1'b0;
   logic [8:0] seconds_o;
   logic [1:0] state_o;
   logic       magnetron_o;
   logic       lamp_o;
   logic       done_o;
   logic       beep_o;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef COOK_TIMER_DONE_BEEP_EN
   localparam logic c_beep = 1'b1;
`else
   localparam logic c_beep = 1'b0;
`endif

   cook_timer #(.TICK_DIV(4), .ADD_STEP(30), .MAX_SEC(511)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .add_sec_i   (add_sec_i),
      .start_i     (start_i),
      .stop_i      (stop_i),
      .door_open_i (door_open_i),
      .seconds_o   (seconds_o),
      .state_o     (state_o),
      .magnetron_o (magnetron_o),
      .lamp_o      (lamp_o),
      .done_o      (done_o),
      .beep_o      (beep_o)
   );

   always #5 clk = ~clk;

   // Stimulus helpers: called on a negedge, return on the following negedge
   task automatic do_reset();
      rst_n = 1'b0;
      add_sec_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; door_open_i = 1'b0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_add();
      add_sec_i = 1'b1; @(negedge clk); add_sec_i = 1'b0;
   endtask

   task automatic pulse_start();
      start_i = 1'b1; @(negedge clk); start_i = 1'b0;
   endtask

   task automatic pulse_stop();
      stop_i = 1'b1; @(negedge clk); stop_i = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({seconds_o, state_o, magnetron_o, lamp_o, done_o, beep_o} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset: sec=%0d st=%b mag=%b lamp=%b done=%b beep=%b, required all 0",
                  seconds_o, state_o, magnetron_o, lamp_o, done_o, beep_o);
      end
   endtask

   task automatic test_add_start();
      do_reset();
      pulse_add(); pulse_add();
      n_checks++;
      if ({state_o, seconds_o} !== {2'b00, 9'd60}) begin
         n_fail++;
         $display("FAIL add_idle: st=%b sec=%0d, required st=00 sec=60", state_o, seconds_o);
      end
      pulse_start();
      n_checks++;
      if ({state_o, magnetron_o, lamp_o, seconds_o} !== {2'b01, 1'b1, 1'b1, 9'd60}) begin
         n_fail++;
         $display("FAIL start_run: st=%b mag=%b lamp=%b sec=%0d, required 01/1/1/60",
                  state_o, magnetron_o, lamp_o, seconds_o);
      end
      wait_cycles(3);
      n_checks++;
      if (seconds_o !== 9'd60) begin
         n_fail++;
         $display("FAIL pre_tick: sec=%0d, required 60", seconds_o);
      end
      wait_cycles(5);
      n_checks++;
      if (seconds_o !== 9'd58) begin
         n_fail++;
         $display("FAIL countdown_8clk: sec=%0d, required 58", seconds_o);
      end
      // add coinciding with a tick: 58 + 30 - 1
      wait_cycles(3);
      pulse_add();
      n_checks++;
      if (seconds_o !== 9'd87) begin
         n_fail++;
         $display("FAIL add_on_tick: sec=%0d, required 87", seconds_o);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 17; i++) pulse_add();
      n_checks++;
      if (seconds_o !== 9'd510) begin
         n_fail++;
         $display("FAIL sat_510: sec=%0d, required 510", seconds_o);
      end
      pulse_add();
      n_checks++;
      if (seconds_o !== 9'd511) begin
         n_fail++;
         $display("FAIL sat_511: sec=%0d, required 511", seconds_o);
      end
      pulse_add();
      n_checks++;
      if (seconds_o !== 9'd511) begin
         n_fail++;
         $display("FAIL sat_hold: sec=%0d, required 511", seconds_o);
      end
   endtask

   task automatic test_door_pause();
      do_reset();
      pulse_add(); pulse_start();
      wait_cycles(102);
      n_checks++;
      if ({state_o, seconds_o} !== {2'b01, 9'd5}) begin
         n_fail++;
         $display("FAIL run_at_5: st=%b sec=%0d, required 01/5", state_o, seconds_o);
      end
      // open the door mid-second; the partial second must be discarded
      door_open_i = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({state_o, magnetron_o, lamp_o, seconds_o} !== {2'b10, 1'b0, 1'b1, 9'd5}) begin
         n_fail++;
         $display("FAIL door_pause: st=%b mag=%b lamp=%b sec=%0d, required 10/0/1/5",
                  state_o, magnetron_o, lamp_o, seconds_o);
      end
      door_open_i = 1'b0;
      @(negedge clk);
      pulse_start();
      wait_cycles(3);
      n_checks++;
      if ({state_o, seconds_o} !== {2'b01, 9'd5}) begin
         n_fail++;
         $display("FAIL resume_hold: st=%b sec=%0d, required 01/5", state_o, seconds_o);
      end
      @(negedge clk);
      n_checks++;
      if (seconds_o !== 9'd4) begin
         n_fail++;
         $display("FAIL resume_tick: sec=%0d, required 4", seconds_o);
      end
   endtask

   task automatic test_quick_start();
      do_reset();
      pulse_start();
      n_checks++;
      if ({state_o, seconds_o} !== {2'b01, 9'd30}) begin
         n_fail++;
         $display("FAIL quick_start: st=%b sec=%0d, required 01/30", state_o, seconds_o);
      end
      do_reset();
      door_open_i = 1'b1;
      pulse_start();
      n_checks++;
      if ({state_o, lamp_o, seconds_o} !== {2'b00, 1'b1, 9'd0}) begin
         n_fail++;
         $display("FAIL start_door_open: st=%b lamp=%b sec=%0d, required 00/1/0",
                  state_o, lamp_o, seconds_o);
      end
      door_open_i = 1'b0;
   endtask

   task automatic test_done();
      do_reset();
      pulse_add(); pulse_start();
      wait_cycles(119);
      n_checks++;
      if ({state_o, seconds_o} !== {2'b01, 9'd1}) begin
         n_fail++;
         $display("FAIL run_at_1: st=%b sec=%0d, required 01/1", state_o, seconds_o);
      end
      @(negedge clk);
      n_checks++;
      if ({state_o, done_o, magnetron_o, lamp_o, beep_o, seconds_o} !==
          {2'b11, 1'b1, 1'b0, 1'b0, c_beep, 9'd0}) begin
         n_fail++;
         $display("FAIL done_enter: st=%b done=%b mag=%b lamp=%b beep=%b sec=%0d, required 11/1/0/0/%b/0",
                  state_o, done_o, magnetron_o, lamp_o, beep_o, seconds_o, c_beep);
      end
      wait_cycles(11);
      n_checks++;
      if (beep_o !== c_beep) begin
         n_fail++;
         $display("FAIL beep_last: beep=%b, required %b", beep_o, c_beep);
      end
      @(negedge clk);
      n_checks++;
      if ({state_o, beep_o} !== {2'b11, 1'b0}) begin
         n_fail++;
         $display("FAIL beep_end: st=%b beep=%b, required 11/0", state_o, beep_o);
      end
      pulse_add();
      n_checks++;
      if ({state_o, done_o, seconds_o} !== {2'b00, 1'b0, 9'd30}) begin
         n_fail++;
         $display("FAIL done_add: st=%b done=%b sec=%0d, required 00/0/30",
                  state_o, done_o, seconds_o);
      end
   endtask

   task automatic test_stop();
      do_reset();
      pulse_add(); pulse_start();
      pulse_add();
      n_checks++;
      if ({state_o, seconds_o} !== {2'b01, 9'd60}) begin
         n_fail++;
         $display("FAIL run_add: st=%b sec=%0d, required 01/60", state_o, seconds_o);
      end
      // stop outranks a simultaneous add
      stop_i = 1'b1; add_sec_i = 1'b1;
      @(negedge clk);
      stop_i = 1'b0; add_sec_i = 1'b0;
      n_checks++;
      if ({state_o, magnetron_o, seconds_o} !== {2'b10, 1'b0, 9'd60}) begin
         n_fail++;
         $display("FAIL stop_pause: st=%b mag=%b sec=%0d, required 10/0/60",
                  state_o, magnetron_o, seconds_o);
      end
      pulse_stop();
      n_checks++;
      if ({state_o, seconds_o} !== {2'b00, 9'd0}) begin
         n_fail++;
         $display("FAIL stop_idle: st=%b sec=%0d, required 00/0", state_o, seconds_o);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      pulse_add(); pulse_start();
      wait_cycles(2);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({seconds_o, state_o, magnetron_o, lamp_o, done_o, beep_o} !== 15'd0) begin
         n_fail++;
         $display("FAIL async_reset: sec=%0d st=%b mag=%b lamp=%b done=%b beep=%b, required all 0",
                  seconds_o, state_o, magnetron_o, lamp_o, done_o, beep_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_add_start();
      test_saturate();
      test_door_pause();
      test_quick_start();
      test_done();
      test_stop();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
